// File: rtl/robin_uart_pkg.sv
// Shared types and constants for the robin buffered UART transmitter.
// Optional parity support is enabled by defining UART_TX_PARITY_EN.
package robin_uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } tx_state_e;

   function automatic int unsigned calc_div(
      input int unsigned clk_hz,
      input int unsigned baud
   );
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter shifter.
// full and level come straight from the registered occupancy count.
module uart_tx_fifo #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          full,
   output logic [AW:0]   level
);

   localparam int DEPTH = 1 << AW;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          push, pop;

   assign full    = level_q[AW];
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Pointer and occupancy update; writes while full are dropped.
   always_comb begin
      push     = wr_en && !full;
      pop      = rd_en && (level_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO, bit timer, shifter and framing FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_buffered
   import robin_uart_pkg::*;
#(
   parameter int SYS_CLK_FREQ    = 12000000,
   parameter int BAUD_RATE       = 115200,
   parameter int FIFO_ADDR_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   output logic                     full,
   output logic [FIFO_ADDR_WIDTH:0] level,
   output logic                     busy,
   output logic                     tx
);

   localparam int DIV      = int'(calc_div(SYS_CLK_FREQ, BAUD_RATE));
   localparam int STOP_CYC = DIV * STOP_BITS;
   localparam int CW       = $clog2(STOP_CYC + 1);

   localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
   localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_CYC - 1);
   localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

   tx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   logic       pop;
   logic [7:0] head;
   logic       have_data;

   uart_tx_fifo #(
      .AW (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .level   (level)
   );

   assign have_data = (level != '0);
   assign busy      = busy_q;
   assign tx        = tx_q;

   // Framing FSM: next state, bit timer, shifter and line value.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (have_data) pop = 1'b1;
         end
         ST_START: begin
            if (cnt_q == '0) begin
               state_d = ST_DATA;
               cnt_d   = BIT_LOAD;
               idx_d   = '0;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == '0) begin
               if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  cnt_d   = BIT_LOAD;
                  tx_d    = par_q;
`else
                  state_d = ST_STOP;
                  cnt_d   = STOP_LOAD;
                  tx_d    = 1'b1;
`endif
               end else begin
                  cnt_d   = BIT_LOAD;
                  idx_d   = idx_q + 1'b1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == '0) begin
               state_d = ST_STOP;
               cnt_d   = STOP_LOAD;
               tx_d    = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_q == '0) begin
               if (have_data) begin
                  pop = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  tx_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
         end
      endcase
      if (pop) begin
         state_d = ST_START;
         cnt_d   = BIT_LOAD;
         shift_d = head;
         tx_d    = 1'b0;
         busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
         par_d   = ^head;
`endif
      end
   end

   // FSM, timer and registered line output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: stimulus pushes expected frames,
// a line decoder pops and compares them as frames appear on tx.
module tb_uart_tx_buffered;

   localparam int DIV = 104;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * DIV;

   typedef struct {
      logic [7:0] data;
      int         start_at;
      logic       par;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full;
   logic [4:0] level;
   logic       busy;
   logic       tx;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   bit   mon_en = 1'b1;
   exp_t sb[$];

   uart_tx_buffered #(
      .SYS_CLK_FREQ    (12000000),
      .BAUD_RATE       (115200),
      .FIFO_ADDR_WIDTH (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .level   (level),
      .busy    (busy),
      .tx      (tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic write_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait_bound", 32'(n < limit), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   // Line decoder: samples each bit mid-period and scores it.
   initial begin : monitor
      int               s;
      logic [NBITS-1:0] bits;
      exp_t             e;
      forever begin
         @(negedge clk);
         if (mon_en && rst === 1'b0 && tx === 1'b0) begin
            s = cyc;
            for (int j = 0; j < NBITS; j++) begin
               wait_until(s + j * DIV + DIV / 2);
               bits[j] = tx;
            end
            n_checks++;
            if (sb.size() == 0) begin
               $display("FAIL frame_expected: got frame 0x%0h at %0d, required none",
                        bits[8:1], s);
            end else begin
               n_pass++;
               e = sb.pop_front();
               chk("start_bit", 32'(bits[0]), 32'd0);
               chk("data_byte", 32'(bits[8:1]), 32'(e.data));
               chk("start_cycle", 32'(s), 32'(e.start_at));
`ifdef UART_TX_PARITY_EN
               chk("parity_bit", 32'(bits[9]), 32'(e.par));
`endif
               chk("stop_bit", 32'(bits[NBITS-1]), 32'd1);
            end
         end
      end
   end

   initial begin : stim
      int k;
      int s;
      int low;

      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single byte, latency and busy fall
      k = cyc + 1;
      sb.push_back('{8'h55, k + 1, 1'b0});
      write_byte(8'h55);
      wait_until(k + FRAME);
      chk("busy_last_cycle", 32'(busy), 32'd1);
      wait_until(k + FRAME + 1);
      chk("busy_fall", 32'(busy), 32'd0);
      wait_idle(2 * FRAME);

      // two back-to-back frames
      k = cyc + 1;
      sb.push_back('{8'hA3, k + 1, 1'b0});
      sb.push_back('{8'h0F, k + 1 + FRAME, 1'b0});
      write_byte(8'hA3);
      write_byte(8'h0F);
      wait_idle(3 * FRAME);

      // fill past capacity
      k = cyc + 1;
      for (int i = 0; i < 17; i++)
         sb.push_back('{8'(i), k + 1 + i * FRAME, ^8'(i)});
      for (int i = 0; i < 18; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i);
         @(negedge clk);
         if (i == 16) begin
            chk("fill_level", 32'(level), 32'd16);
            chk("fill_full", 32'(full), 32'd1);
         end
      end
      wr_en = 1'b0;
      chk("drop_when_full", 32'(level), 32'd16);
      // write while full coinciding with a pop
      wait_until(k + FRAME);
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      @(negedge clk);
      wr_en   = 1'b0;
      chk("full_pop_level", 32'(level), 32'd15);
      chk("full_pop_full", 32'(full), 32'd0);
      for (int i = 2; i < 17; i++) begin
         wait_until(k + 1 + i * FRAME);
         chk("drain_level", 32'(level), 32'(16 - i));
      end
      wait_idle(20 * FRAME);

      // reset during data bit 3 of 0xFF
      mon_en = 1'b0;
      k = cyc + 1;
      s = k + 1;
      write_byte(8'hFF);
      for (int i = 1; i < 6; i++) write_byte(8'(i));
      chk("pre_rst_level", 32'(level), 32'd5);
      wait_until(s + 4 * DIV + 49);
      chk("pre_rst_bit3", 32'(tx), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_full", 32'(full), 32'd0);
      low = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) low++;
      end
      chk("line_idle_after_rst", 32'(low), 32'd0);
      mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
      // parity frames
      k = cyc + 1;
      sb.push_back('{8'h07, k + 1, 1'b1});
      sb.push_back('{8'h03, k + 1 + FRAME, 1'b0});
      write_byte(8'h07);
      write_byte(8'h03);
      wait_until(k + 2 * FRAME);
      chk("par_busy_last", 32'(busy), 32'd1);
      wait_until(k + 2 * FRAME + 1);
      chk("par_busy_fall", 32'(busy), 32'd0);
      wait_idle(3 * FRAME);
`endif

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
